bht_pc_control: RTL and testbench
=================================

Name: bht_pc_control

Overview:
- Parametrised successor to the stage-3 PC-select logic for the 3-stage RISC-V core.
- Adds a BHT of 2-bit saturating counters that predicts conditional branches at fetch and predicts JAL as taken.
- Resolves branches and JALR in stage 3 and issues redirect/flush on mispredict.
- Keeps branch and mispredict performance counters.
- Drives the fetch next-PC mux directly.

Parameters:
- BHT_ENTRIES, 64, number of counters; power of 2, at least 2. IDX_W = log2(BHT_ENTRIES).
- INIT_STATE, 2'b01, counter value after reset (weakly not-taken).
- ENABLE_PRED, 1, when 0 conditional branches are predicted not-taken and BHT updates are suppressed. JAL is still predicted taken.
- RESET_PC, 32'h4000_0000, PC driven while in reset.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- fetch_pc  in  32  PC of the instruction being fetched
- fetch_inst  in  32  instruction at fetch_pc
- fetch_valid  in  1  fetch slot holds a real instruction
- pred_taken  out  1  fetch instruction predicted taken; pipelined by the core alongside the instruction
- res_valid  in  1  stage-3 instruction is valid (not a bubble or flushed)
- res_pc  in  32  stage-3 PC
- res_inst  in  32  stage-3 instruction
- res_pred_taken  in  1  pred_taken carried down with res_inst
- res_breq  in  1  branch comparator equal
- res_brlt  in  1  branch comparator less-than; signedness already applied
- res_jalr_target  in  32  rs1+imm from ALU
- pc_sel  out  2  0 = pc+4, 1 = predicted target, 2 = redirect, 3 = reset
- next_pc  out  32  PC to load into the fetch PC register
- flush  out  1  kill the younger instructions in fetch and stage 2
- branch_count  out  CNT_W  resolved conditional branches
- mispredict_count  out  CNT_W  redirects issued

Behaviour:
- Reset (async, rst high):
  - All BHT entries set to INIT_STATE; both counters cleared to 0.
  - While rst is high: pc_sel = 3, next_pc = RESET_PC, flush = 0, pred_taken = 0.
- Index: idx = pc[IDX_W+1:2].
- Prediction (combinational from fetch inputs; pred_taken = 0 if fetch_valid = 0):
  - JAL (opcode5 11011): taken, target = fetch_pc + J-imm.
  - BRANCH (opcode5 11000): taken iff ENABLE_PRED and bht[idx][1] = 1; target = fetch_pc + B-imm.
  - Any other opcode, including JALR: not taken.
- Resolution (combinational from stage-3 inputs; only when res_valid = 1):
  - Actual outcome by func3: BEQ = breq, BNE = !breq, BLT/BLTU = brlt, BGE/BGEU = !brlt, func3 2 or 3 = not taken.
  - Conditional-branch mispredict iff actual != res_pred_taken.
  - Redirect target: actual taken gives res_pc + B-imm; actual not-taken gives res_pc + 4.
  - JALR always redirects, to {res_jalr_target[31:1], 1'b0}.
  - JAL never redirects.
- Output priority: rst > redirect (pc_sel = 2, flush = 1) > fetch predicted taken (pc_sel = 1) > pc_sel = 0 with next_pc = fetch_pc + 4.
- Update at posedge clk, for a valid stage-3 conditional branch with ENABLE_PRED = 1:
  - bht[idx(res_pc)] increments if taken, saturating at 3.
  - Otherwise it decrements, saturating at 0.
- Counters:
  - branch_count increments for each valid resolved conditional branch.
  - mispredict_count increments on each redirect cycle.
  - Both saturate at all-ones; they do not wrap.
- Same-cycle read and write to the same index: prediction uses the pre-update value; no bypass.
- Redirect and a predicted-taken fetch in the same cycle: redirect wins. The fetch instruction is flushed by the core, so its pred_taken is irrelevant.
- Reset asserted mid-operation: counters and BHT clear immediately. No update is applied on the edge during reset.
- Latency:
  - Prediction and redirect are zero-cycle combinational.
  - BHT and counter updates are visible the cycle after resolution.

Test Plan:
- Reset: rst = 1, then release -> pc_sel = 3 and next_pc = 32'h4000_0000 during reset. After release, a BEQ fetched at 0x4000_0010 gives pred_taken = 0 and both counters read 0.
- Training: a BNE at 0x100 with offset −8 resolves taken 2× -> bht[0] goes 1→2→3. Third fetch gives pred_taken = 1, next_pc = 0xF8, pc_sel = 1. Saturation holds at 3 after a further taken resolve.
- Mispredict: a BLT predicted taken at 0x200 resolves not-taken (brlt = 0) -> flush = 1, pc_sel = 2, next_pc = 0x204, mispredict_count increments, counter decrements.
- JAL/JALR: JAL at 0x300 with +0x40 -> pred_taken = 1, next_pc = 0x340, no later redirect. JALR with res_jalr_target = 0x1235 -> redirect to 0x1234, flush = 1.
- Collision: fetch of a predicted-taken branch in the same cycle as a stage-3 mispredict -> pc_sel = 2. Fetch and resolve at the same idx use the old counter value.
- ENABLE_PRED = 0: ten taken BEQs -> pred_taken stays 0, a redirect every time, mispredict_count = 10, branch_count = 10.

Source files
------------

// File: rtl/bht_pc_control_if.sv
// rtl/bht_pc_control_if.sv - fetch/resolve/next-PC bundle between the core and bht_pc_control
//
// Purpose: groups the fetch-side prediction signals, the stage-3 resolution
// signals and the PC-select outputs into one bundle.
// Modports:
//   master - core side: drives fetch_* and res_*; sees pred_taken, pc_sel,
//            next_pc, flush and the performance counters.
//   slave  - bht_pc_control side: the mirror image.
interface bht_pc_control_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      fetch_pc;
  logic [31:0]      fetch_inst;
  logic             fetch_valid;
  logic             pred_taken;
  logic             res_valid;
  logic [31:0]      res_pc;
  logic [31:0]      res_inst;
  logic             res_pred_taken;
  logic             res_breq;
  logic             res_brlt;
  logic [31:0]      res_jalr_target;
  logic [1:0]       pc_sel;
  logic [31:0]      next_pc;
  logic             flush;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] mispredict_count;

  modport master (
    output fetch_pc, fetch_inst, fetch_valid,
    output res_valid, res_pc, res_inst, res_pred_taken, res_breq, res_brlt, res_jalr_target,
    input  pred_taken, pc_sel, next_pc, flush, branch_count, mispredict_count
  );

  modport slave (
    input  fetch_pc, fetch_inst, fetch_valid,
    input  res_valid, res_pc, res_inst, res_pred_taken, res_breq, res_brlt, res_jalr_target,
    output pred_taken, pc_sel, next_pc, flush, branch_count, mispredict_count
  );
endinterface

// File: rtl/bht_pc_control.sv
// rtl/bht_pc_control.sv - BHT branch predictor and stage-3 PC select for the 3-stage core
//
// Purpose: predicts conditional branches at fetch from a table of 2-bit
// saturating counters (JAL always taken), resolves branches and JALR in
// stage 3, issues redirect/flush on mispredict and drives the fetch next-PC mux.
// Ports:
//   clk  - core clock
//   rst  - asynchronous, active-high reset
//   bus  - bht_pc_control_if.slave: fetch_* / res_* inputs, pred_taken,
//          pc_sel (0 pc+4, 1 predicted target, 2 redirect, 3 reset), next_pc,
//          flush, branch_count, mispredict_count
module bht_pc_control #(
  parameter int          BHT_ENTRIES = 64,
  parameter logic [1:0]  INIT_STATE  = 2'b01,
  parameter bit          ENABLE_PRED = 1'b1,
  parameter logic [31:0] RESET_PC    = 32'h4000_0000,
  parameter int          CNT_W       = 32
) (
  input logic           clk,
  input logic           rst,
  bht_pc_control_if.slave bus
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;

  function automatic logic [31:0] imm_b(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] inst);
    return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

  logic [1:0]       bht_q [BHT_ENTRIES];
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  // ---------------- fetch-side prediction ----------------
  logic [4:0]       f_op;
  logic             f_is_jal, f_is_br;
  logic [IDX_W-1:0] f_idx;
  logic [1:0]       f_ctr;
  logic             f_taken;
  logic [31:0]      f_target;

  assign f_op     = bus.fetch_inst[6:2];
  assign f_is_jal = (f_op == OP_JAL);
  assign f_is_br  = (f_op == OP_BRANCH);
  assign f_idx    = bus.fetch_pc[IDX_W+1:2];
  // Reads the registered table: a same-cycle update to this index is not bypassed.
  assign f_ctr    = bht_q[f_idx];
  assign f_taken  = bus.fetch_valid && (f_is_jal || (f_is_br && ENABLE_PRED && f_ctr[1]));
  assign f_target = bus.fetch_pc + (f_is_jal ? imm_j(bus.fetch_inst) : imm_b(bus.fetch_inst));

  // ---------------- stage-3 resolution ----------------
  logic [4:0]       r_op;
  logic [2:0]       r_func3;
  logic             r_is_br, r_is_jalr;
  logic             r_actual;
  logic             r_mispred;
  logic             redirect;
  logic [31:0]      redirect_pc;
  logic [IDX_W-1:0] r_idx;
  logic [1:0]       r_ctr;
  logic [1:0]       bht_upd_d;
  logic             bht_we;

  assign r_op      = bus.res_inst[6:2];
  assign r_func3   = bus.res_inst[14:12];
  assign r_is_br   = bus.res_valid && (r_op == OP_BRANCH);
  assign r_is_jalr = bus.res_valid && (r_op == OP_JALR);

  always_comb begin
    r_actual = 1'b0;
    unique case (r_func3)
      3'b000:         r_actual = bus.res_breq;    // BEQ
      3'b001:         r_actual = !bus.res_breq;   // BNE
      3'b100, 3'b110: r_actual = bus.res_brlt;    // BLT / BLTU
      3'b101, 3'b111: r_actual = !bus.res_brlt;   // BGE / BGEU
      default:        r_actual = 1'b0;            // reserved encodings never branch
    endcase
  end

  assign r_mispred = r_is_br && (r_actual != bus.res_pred_taken);
  assign redirect  = r_mispred || r_is_jalr;

  always_comb begin
    if (r_is_jalr)
      redirect_pc = {bus.res_jalr_target[31:1], 1'b0};
    else if (r_actual)
      redirect_pc = bus.res_pc + imm_b(bus.res_inst);
    else
      redirect_pc = bus.res_pc + 32'd4;
  end

  assign r_idx  = bus.res_pc[IDX_W+1:2];
  assign r_ctr  = bht_q[r_idx];
  assign bht_we = r_is_br && ENABLE_PRED;

  always_comb begin
    bht_upd_d = r_ctr;
    if (r_actual) begin
      if (r_ctr != 2'd3) bht_upd_d = r_ctr + 2'd1;
    end else begin
      if (r_ctr != 2'd0) bht_upd_d = r_ctr - 2'd1;
    end
  end

  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (r_is_br && (branch_cnt_q != '1))
      branch_cnt_d = branch_cnt_q + CNT_W'(1);
    if (redirect && (mispred_cnt_q != '1))
      mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= INIT_STATE;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
      if (bht_we) bht_q[r_idx] <= bht_upd_d;
    end
  end

  // ---------------- next-PC mux ----------------
  always_comb begin
    bus.pc_sel     = 2'd0;
    bus.next_pc    = bus.fetch_pc + 32'd4;
    bus.flush      = 1'b0;
    bus.pred_taken = f_taken;
    if (rst) begin
      bus.pc_sel     = 2'd3;
      bus.next_pc    = RESET_PC;
      bus.pred_taken = 1'b0;
    end else if (redirect) begin
      bus.pc_sel  = 2'd2;
      bus.next_pc = redirect_pc;
      bus.flush   = 1'b1;
    end else if (f_taken) begin
      bus.pc_sel  = 2'd1;
      bus.next_pc = f_target;
    end
  end

  assign bus.branch_count     = branch_cnt_q;
  assign bus.mispredict_count = mispred_cnt_q;

  logic unused_bits;
  assign unused_bits = ^{bus.fetch_inst[1:0], bus.res_inst[24:15], bus.res_inst[1:0],
                         bus.res_jalr_target[0]};

endmodule

// File: tb/tb_bht_pc_control.sv
// tb/tb_bht_pc_control.sv - directed bench for bht_pc_control
module tb_bht_pc_control;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  bht_pc_control_if #(.CNT_W(32)) bus ();
  bht_pc_control_if #(.CNT_W(32)) bus_np ();

  bht_pc_control #(.ENABLE_PRED(1'b1)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  bht_pc_control #(.ENABLE_PRED(1'b0)) u_dut_np (
    .clk (clk),
    .rst (rst),
    .bus (bus_np)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [31:0] off);
    return {off[12], off[10:5], 5'd2, 5'd1, f3, off[4:1], off[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [31:0] off);
    return {off[20], off[10:1], off[11], off[19:12], 5'd1, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_jalr();
    return {12'd0, 5'd1, 3'b000, 5'd1, 7'b1100111};
  endfunction

  task automatic set_fetch(input logic [31:0] pc, input logic [31:0] inst, input logic v);
    bus.fetch_pc    = pc;
    bus.fetch_inst  = inst;
    bus.fetch_valid = v;
  endtask

  task automatic set_res(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                         input logic pt, input logic eq, input logic lt, input logic [31:0] jt);
    bus.res_valid       = v;
    bus.res_pc          = pc;
    bus.res_inst        = inst;
    bus.res_pred_taken  = pt;
    bus.res_breq        = eq;
    bus.res_brlt        = lt;
    bus.res_jalr_target = jt;
  endtask

  task automatic clear_res();
    set_res(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  logic [31:0] bne_m8, blt_p16, beq_p8, jal_p40;

  initial begin
    bne_m8  = enc_b(3'b001, 32'hFFFF_FFF8);
    blt_p16 = enc_b(3'b100, 32'h0000_0010);
    beq_p8  = enc_b(3'b000, 32'h0000_0008);
    jal_p40 = enc_j(32'h0000_0040);

    bus_np.fetch_pc = 32'h0; bus_np.fetch_inst = 32'h0; bus_np.fetch_valid = 1'b0;
    bus_np.res_valid = 1'b0; bus_np.res_pc = 32'h0; bus_np.res_inst = 32'h0;
    bus_np.res_pred_taken = 1'b0; bus_np.res_breq = 1'b0; bus_np.res_brlt = 1'b0;
    bus_np.res_jalr_target = 32'h0;

    // ---- reset ----
    set_fetch(32'h300, jal_p40, 1'b1);
    clear_res();
    #2;
    chk("rst_pc_sel", 32'(bus.pc_sel), 32'd3);
    chk("rst_next_pc", bus.next_pc, 32'h4000_0000);
    chk("rst_flush", 32'(bus.flush), 32'd0);
    chk("rst_pred", 32'(bus.pred_taken), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    set_fetch(32'h4000_0010, enc_b(3'b000, 32'h10), 1'b1);
    #1;
    chk("post_rst_pred", 32'(bus.pred_taken), 32'd0);
    chk("post_rst_pc_sel", 32'(bus.pc_sel), 32'd0);
    chk("post_rst_next_pc", bus.next_pc, 32'h4000_0014);
    chk("post_rst_bcnt", bus.branch_count, 32'd0);
    chk("post_rst_mcnt", bus.mispredict_count, 32'd0);
    @(negedge clk);

    // ---- training: BNE at 0x100, -8 ----
    set_fetch(32'h100, bne_m8, 1'b1);
    set_res(1'b1, 32'h100, bne_m8, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    chk("t1_pred", 32'(bus.pred_taken), 32'd0);
    chk("t1_flush", 32'(bus.flush), 32'd1);
    chk("t1_pc_sel", 32'(bus.pc_sel), 32'd2);
    chk("t1_next_pc", bus.next_pc, 32'hF8);
    @(negedge clk);
    chk("t1_bcnt", bus.branch_count, 32'd1);
    chk("t1_mcnt", bus.mispredict_count, 32'd1);
    #1;
    chk("t2_pc_sel", 32'(bus.pc_sel), 32'd2);
    @(negedge clk);
    chk("t2_mcnt", bus.mispredict_count, 32'd2);
    clear_res();
    #1;
    chk("t3_pred", 32'(bus.pred_taken), 32'd1);
    chk("t3_pc_sel", 32'(bus.pc_sel), 32'd1);
    chk("t3_next_pc", bus.next_pc, 32'hF8);
    @(negedge clk);
    set_res(1'b1, 32'h100, bne_m8, 1'b1, 1'b0, 1'b0, 32'h0);
    #1;
    chk("t4_flush", 32'(bus.flush), 32'd0);
    chk("t4_pc_sel", 32'(bus.pc_sel), 32'd1);
    @(negedge clk);
    chk("t4_bcnt", bus.branch_count, 32'd3);
    chk("t4_mcnt", bus.mispredict_count, 32'd2);
    set_res(1'b1, 32'h100, bne_m8, 1'b1, 1'b1, 1'b0, 32'h0);
    #1;
    chk("t5_flush", 32'(bus.flush), 32'd1);
    chk("t5_next_pc", bus.next_pc, 32'h104);
    @(negedge clk);
    clear_res();
    #1;
    chk("t6_sat_pred", 32'(bus.pred_taken), 32'd1);
    chk("t6_mcnt", bus.mispredict_count, 32'd3);
    chk("t6_bcnt", bus.branch_count, 32'd4);
    @(negedge clk);

    // ---- mispredict: BLT at 0x200, +16 ----
    set_fetch(32'h200, blt_p16, 1'b1);
    #1;
    chk("m1_pred", 32'(bus.pred_taken), 32'd1);
    chk("m1_next_pc", bus.next_pc, 32'h210);
    @(negedge clk);
    set_fetch(32'h210, 32'h0, 1'b0);
    set_res(1'b1, 32'h200, blt_p16, 1'b1, 1'b0, 1'b0, 32'h0);
    #1;
    chk("m2_flush", 32'(bus.flush), 32'd1);
    chk("m2_pc_sel", 32'(bus.pc_sel), 32'd2);
    chk("m2_next_pc", bus.next_pc, 32'h204);
    @(negedge clk);
    clear_res();
    set_fetch(32'h200, blt_p16, 1'b1);
    #1;
    chk("m3_mcnt", bus.mispredict_count, 32'd4);
    chk("m3_pred_dec", 32'(bus.pred_taken), 32'd0);
    chk("m3_next_pc", bus.next_pc, 32'h204);
    @(negedge clk);

    // ---- JAL / JALR ----
    set_fetch(32'h300, jal_p40, 1'b1);
    #1;
    chk("j1_pred", 32'(bus.pred_taken), 32'd1);
    chk("j1_pc_sel", 32'(bus.pc_sel), 32'd1);
    chk("j1_next_pc", bus.next_pc, 32'h340);
    @(negedge clk);
    set_fetch(32'h340, 32'h0, 1'b0);
    set_res(1'b1, 32'h300, jal_p40, 1'b1, 1'b0, 1'b0, 32'h0);
    #1;
    chk("j2_flush", 32'(bus.flush), 32'd0);
    chk("j2_pc_sel", 32'(bus.pc_sel), 32'd0);
    chk("j2_next_pc", bus.next_pc, 32'h344);
    @(negedge clk);
    set_res(1'b1, 32'h344, enc_jalr(), 1'b0, 1'b0, 1'b0, 32'h1235);
    #1;
    chk("jalr_flush", 32'(bus.flush), 32'd1);
    chk("jalr_pc_sel", 32'(bus.pc_sel), 32'd2);
    chk("jalr_next_pc", bus.next_pc, 32'h1234);
    @(negedge clk);
    chk("jalr_mcnt", bus.mispredict_count, 32'd5);
    chk("jalr_bcnt", bus.branch_count, 32'd5);

    // ---- collisions (bht[0] = 1 here) ----
    set_fetch(32'h300, jal_p40, 1'b1);
    set_res(1'b1, 32'h400, beq_p8, 1'b1, 1'b0, 1'b0, 32'h0);
    #1;
    chk("c1_pc_sel", 32'(bus.pc_sel), 32'd2);
    chk("c1_next_pc", bus.next_pc, 32'h404);
    @(negedge clk);
    set_fetch(32'h500, beq_p8, 1'b1);
    set_res(1'b1, 32'h400, beq_p8, 1'b0, 1'b1, 1'b0, 32'h0);
    #1;
    chk("c2_pred", 32'(bus.pred_taken), 32'd0);
    chk("c2_next_pc", bus.next_pc, 32'h408);
    @(negedge clk);
    #1;
    chk("c3_old_value_pred", 32'(bus.pred_taken), 32'd0);
    @(negedge clk);
    clear_res();
    #1;
    chk("c4_pred", 32'(bus.pred_taken), 32'd1);
    chk("c4_next_pc", bus.next_pc, 32'h508);
    chk("c4_bcnt", bus.branch_count, 32'd8);
    chk("c4_mcnt", bus.mispredict_count, 32'd8);

    // ---- mid-operation reset with a resolve pending across the edge ----
    set_res(1'b1, 32'h400, beq_p8, 1'b0, 1'b1, 1'b0, 32'h0);
    #1;
    rst = 1'b1;
    #1;
    chk("mr_bcnt", bus.branch_count, 32'd0);
    chk("mr_mcnt", bus.mispredict_count, 32'd0);
    chk("mr_pc_sel", 32'(bus.pc_sel), 32'd3);
    chk("mr_pred", 32'(bus.pred_taken), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    clear_res();
    #1;
    chk("mr_bht_pred", 32'(bus.pred_taken), 32'd0);
    chk("mr_bcnt_after", bus.branch_count, 32'd0);
    @(negedge clk);
    set_fetch(32'h0, 32'h0, 1'b0);

    // ---- ENABLE_PRED = 0 ----
    for (int i = 0; i < 10; i++) begin
      bus_np.fetch_pc       = 32'h600;
      bus_np.fetch_inst     = beq_p8;
      bus_np.fetch_valid    = 1'b1;
      bus_np.res_valid      = 1'b1;
      bus_np.res_pc         = 32'h600;
      bus_np.res_inst       = beq_p8;
      bus_np.res_pred_taken = 1'b0;
      bus_np.res_breq       = 1'b1;
      #1;
      chk("np_pred", 32'(bus_np.pred_taken), 32'd0);
      chk("np_flush", 32'(bus_np.flush), 32'd1);
      chk("np_next_pc", bus_np.next_pc, 32'h608);
      @(negedge clk);
    end
    bus_np.res_valid  = 1'b0;
    bus_np.fetch_inst = jal_p40;
    #1;
    chk("np_bcnt", bus_np.branch_count, 32'd10);
    chk("np_mcnt", bus_np.mispredict_count, 32'd10);
    chk("np_jal_pred", 32'(bus_np.pred_taken), 32'd1);
    chk("np_jal_next_pc", bus_np.next_pc, 32'h640);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
